// File: rtl/tag_lookup_ctrl.sv
// Lookup/fill/state-change controller for the two synchronous-read tag RAMs of a
// 2-way set-associative L1 with MSI line states and per-set LRU bits.
module tag_lookup_ctrl #(
    parameter int AWIDTH = 3,
    parameter int TWIDTH = 14
) (
    input  logic                clock,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [1:0]          req_op,
    input  logic [AWIDTH-1:0]   req_index,
    input  logic [TWIDTH-1:0]   req_tag,
    input  logic [1:0]          req_state,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic                resp_hit,
    output logic                resp_way,
    output logic [1:0]          resp_state,
    output logic [TWIDTH-1:0]   resp_victim_tag,
    output logic                resp_multi_hit,
    output logic [AWIDTH-1:0]   tag_addr,
    output logic [TWIDTH+1:0]   tag_din,
    output logic                tag_we0,
    output logic                tag_we1,
    input  logic [TWIDTH+1:0]   tag_dout0,
    input  logic [TWIDTH+1:0]   tag_dout1
);

    localparam int DEPTH  = 1 << AWIDTH;
    localparam int DWIDTH = TWIDTH + 2;

    localparam logic [1:0] OP_FILL     = 2'b01;
    localparam logic [1:0] OP_SETSTATE = 2'b10;
    localparam logic [1:0] ST_INVALID  = 2'b00;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CMP,
        WR,
        RESP
    } state_t;

    state_t              state;
    logic [1:0]          op_q;
    logic [AWIDTH-1:0]   index_q;
    logic [TWIDTH-1:0]   tag_q;
    logic [1:0]          new_state_q;
    logic [DEPTH-1:0]    lru;

    logic [1:0]          st0;
    logic [1:0]          st1;
    logic [TWIDTH-1:0]   tg0;
    logic [TWIDTH-1:0]   tg1;
    logic                match0;
    logic                match1;
    logic                hit;
    logic                hit_way;
    logic                victim_way;
    logic                fill_way;
    logic [1:0]          hit_state;
    logic [TWIDTH-1:0]   hit_tag;
    logic [1:0]          fill_state;
    logic [TWIDTH-1:0]   fill_tag;
    logic                is_fill;
    logic                is_setstate;

    // Way compare on the RAM read data; only meaningful during CMP, when dout
    // reflects the address latched at the end of RD.
    always_comb begin
        st0         = tag_dout0[DWIDTH-1:TWIDTH];
        st1         = tag_dout1[DWIDTH-1:TWIDTH];
        tg0         = tag_dout0[TWIDTH-1:0];
        tg1         = tag_dout1[TWIDTH-1:0];
        match0      = (tg0 == tag_q) && (st0 != ST_INVALID);
        match1      = (tg1 == tag_q) && (st1 != ST_INVALID);
        hit         = match0 | match1;
        hit_way     = !match0;
        hit_state   = hit_way ? st1 : st0;
        hit_tag     = hit_way ? tg1 : tg0;
        victim_way  = lru[index_q];
        if (st0 == ST_INVALID) begin
            victim_way = 1'b0;
        end else if (st1 == ST_INVALID) begin
            victim_way = 1'b1;
        end
        fill_way    = hit ? hit_way : victim_way;
        fill_state  = fill_way ? st1 : st0;
        fill_tag    = fill_way ? tg1 : tg0;
        is_fill     = (op_q == OP_FILL);
        is_setstate = (op_q == OP_SETSTATE);
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            req_ready       <= 1'b1;
            resp_valid      <= 1'b0;
            resp_hit        <= 1'b0;
            resp_way        <= 1'b0;
            resp_state      <= 2'b00;
            resp_victim_tag <= '0;
            resp_multi_hit  <= 1'b0;
            tag_addr        <= '0;
            tag_din         <= '0;
            tag_we0         <= 1'b0;
            tag_we1         <= 1'b0;
            op_q            <= 2'b00;
            index_q         <= '0;
            tag_q           <= '0;
            new_state_q     <= 2'b00;
            lru             <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_q        <= req_op;
                        index_q     <= req_index;
                        tag_q       <= req_tag;
                        new_state_q <= req_state;
                        tag_addr    <= req_index;
                        req_ready   <= 1'b0;
                        state       <= RD;
                    end
                end

                RD: begin
                    state <= CMP;
                end

                CMP: begin
                    resp_hit        <= hit;
                    resp_multi_hit  <= match0 & match1;
                    resp_victim_tag <= '0;
                    if (is_fill) begin
                        resp_way        <= fill_way;
                        resp_state      <= fill_state;
                        resp_victim_tag <= fill_tag;
                        tag_din         <= {new_state_q, tag_q};
                        tag_we0         <= !fill_way;
                        tag_we1         <= fill_way;
                        lru[index_q]    <= !fill_way;
                        state           <= WR;
                    end else begin
                        resp_way   <= hit ? hit_way : 1'b0;
                        resp_state <= hit ? hit_state : 2'b00;
                        if (is_setstate && hit) begin
                            tag_din <= {new_state_q, hit_tag};
                            tag_we0 <= !hit_way;
                            tag_we1 <= hit_way;
                            state   <= WR;
                        end else begin
                            // LOOKUP (and reserved op) refreshes recency; SETSTATE never does.
                            if (!is_setstate && hit) begin
                                lru[index_q] <= !hit_way;
                            end
                            resp_valid <= 1'b1;
                            state      <= RESP;
                        end
                    end
                end

                WR: begin
                    tag_we0    <= 1'b0;
                    tag_we1    <= 1'b0;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end

                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end

                default: begin
                    tag_we0    <= 1'b0;
                    tag_we1    <= 1'b0;
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tag_lookup_ctrl.sv
// Bench for tag_lookup_ctrl: two behavioural tag RAMs, a set/way reference model,
// and scoreboard queues for responses and tag writes checked by separate monitors.
module tb_tag_lookup_ctrl;

    localparam int AW    = 3;
    localparam int TW    = 14;
    localparam int DW    = TW + 2;
    localparam int DEPTH = 1 << AW;

    logic            clock;
    logic            rst_n;
    logic            req_valid;
    logic            req_ready;
    logic [1:0]      req_op;
    logic [AW-1:0]   req_index;
    logic [TW-1:0]   req_tag;
    logic [1:0]      req_state;
    logic            resp_valid;
    logic            resp_ready;
    logic            resp_hit;
    logic            resp_way;
    logic [1:0]      resp_state;
    logic [TW-1:0]   resp_victim_tag;
    logic            resp_multi_hit;
    logic [AW-1:0]   tag_addr;
    logic [DW-1:0]   tag_din;
    logic            tag_we0;
    logic            tag_we1;
    logic [DW-1:0]   tag_dout0;
    logic [DW-1:0]   tag_dout1;

    tag_lookup_ctrl #(.AWIDTH(AW), .TWIDTH(TW)) dut (
        .clock(clock), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_index(req_index), .req_tag(req_tag), .req_state(req_state),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_hit(resp_hit),
        .resp_way(resp_way), .resp_state(resp_state), .resp_victim_tag(resp_victim_tag),
        .resp_multi_hit(resp_multi_hit), .tag_addr(tag_addr), .tag_din(tag_din),
        .tag_we0(tag_we0), .tag_we1(tag_we1), .tag_dout0(tag_dout0), .tag_dout1(tag_dout1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Tag RAMs with a side port so the bench can preload entries.
    logic [DW-1:0] mem0 [DEPTH];
    logic [DW-1:0] mem1 [DEPTH];
    logic          pre_we;
    logic          pre_way;
    logic [AW-1:0] pre_idx;
    logic [DW-1:0] pre_data;

    always @(posedge clock) begin
        if (tag_we0) mem0[tag_addr] <= tag_din;
        if (tag_we1) mem1[tag_addr] <= tag_din;
        if (pre_we) begin
            if (pre_way) mem1[pre_idx] <= pre_data;
            else         mem0[pre_idx] <= pre_data;
        end
        tag_dout0 <= mem0[tag_addr];
        tag_dout1 <= mem1[tag_addr];
    end

    typedef struct packed {
        logic          hit;
        logic          way;
        logic [1:0]    st;
        logic [TW-1:0] vt;
        logic          multi;
        logic [7:0]    lat;
        logic          wr;
        logic          wway;
        logic [DW-1:0] wdata;
        logic [AW-1:0] idx;
        logic          lru_upd;
        logic          lru_val;
    } exp_t;

    exp_t resp_q[$];
    exp_t wr_q[$];

    logic [1:0]    m_st  [2][DEPTH];
    logic [TW-1:0] m_tag [2][DEPTH];
    logic          m_lru [DEPTH];

    int total = 0;
    int bad   = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: per-way {state,tag} arrays plus one LRU bit per set.
    task automatic model(input logic [1:0] op, input logic [AW-1:0] idx, input logic [TW-1:0] tag,
                         input logic [1:0] ns, output exp_t e);
        logic m0, m1, w;
        m0 = (m_st[0][idx] != 2'b00) && (m_tag[0][idx] == tag);
        m1 = (m_st[1][idx] != 2'b00) && (m_tag[1][idx] == tag);
        e = '0;
        e.idx   = idx;
        e.hit   = m0 || m1;
        e.multi = m0 && m1;
        e.lat   = 8'd3;
        if (op == 2'b01) begin
            if (m0)                       w = 1'b0;
            else if (m1)                  w = 1'b1;
            else if (m_st[0][idx] == 2'b00) w = 1'b0;
            else if (m_st[1][idx] == 2'b00) w = 1'b1;
            else                          w = m_lru[idx];
            e.way = w; e.st = m_st[w][idx]; e.vt = m_tag[w][idx];
            e.wr = 1'b1; e.wway = w; e.wdata = {ns, tag}; e.lat = 8'd4;
            e.lru_upd = 1'b1; e.lru_val = !w;
        end else if (op == 2'b10) begin
            if (e.hit) begin
                w = m0 ? 1'b0 : 1'b1;
                e.way = w; e.st = m_st[w][idx];
                e.wr = 1'b1; e.wway = w; e.wdata = {ns, m_tag[w][idx]}; e.lat = 8'd4;
            end
        end else if (e.hit) begin
            w = m0 ? 1'b0 : 1'b1;
            e.way = w; e.st = m_st[w][idx];
            e.lru_upd = 1'b1; e.lru_val = !w;
        end
    endtask

    task automatic commit(input exp_t e);
        if (e.wr) begin
            m_st[e.wway][e.idx]  = e.wdata[DW-1:TW];
            m_tag[e.wway][e.idx] = e.wdata[TW-1:0];
        end
        if (e.lru_upd) m_lru[e.idx] = e.lru_val;
    endtask

    task automatic preload(input logic way, input logic [AW-1:0] idx, input logic [1:0] st,
                           input logic [TW-1:0] tag);
        pre_we = 1'b1; pre_way = way; pre_idx = idx; pre_data = {st, tag};
        @(posedge clock); #1;
        pre_we = 1'b0;
        m_st[way][idx]  = st;
        m_tag[way][idx] = tag;
    endtask

    always @(negedge clock) begin
        if (rst_n && resp_valid && resp_ready) begin
            if (resp_q.size() == 0) begin
                checkOutput("unexpected_resp", 1, 0);
            end else begin
                exp_t e;
                e = resp_q.pop_front();
                checkOutput("resp_hit", resp_hit, e.hit);
                checkOutput("resp_way", resp_way, e.way);
                checkOutput("resp_state", resp_state, e.st);
                checkOutput("resp_victim_tag", resp_victim_tag, e.vt);
                checkOutput("resp_multi_hit", resp_multi_hit, e.multi);
                checkOutput("resp_tag_addr", tag_addr, e.idx);
            end
        end
    end

    always @(negedge clock) begin
        if (rst_n && (tag_we0 || tag_we1)) begin
            if (wr_q.size() == 0) begin
                checkOutput("unexpected_write", {tag_we1, tag_we0}, 0);
            end else begin
                exp_t e;
                e = wr_q.pop_front();
                checkOutput("wr_both_we", tag_we0 && tag_we1, 0);
                checkOutput("wr_way", tag_we1, e.wway);
                checkOutput("wr_addr", tag_addr, e.idx);
                checkOutput("wr_data", tag_din, e.wdata);
            end
        end
    end

    // Called at posedge+1 with the DUT idle; returns at posedge+1 after the response leaves.
    task automatic applyStimulus(input logic [1:0] op, input logic [AW-1:0] idx, input logic [TW-1:0] tag,
                                 input logic [1:0] ns, input int stall, input bit poke);
        exp_t e;
        int   n;
        model(op, idx, tag, ns, e);
        resp_q.push_back(e);
        if (e.wr) wr_q.push_back(e);
        commit(e);
        req_op = op; req_index = idx; req_tag = tag; req_state = ns;
        req_valid = 1'b1; resp_ready = 1'b0;
        n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clock); #1; n++;
        end
        checkOutput("accept_ready", req_ready, 1);
        @(posedge clock); #1;
        req_valid = 1'b0;
        n = 1;
        while (!resp_valid && n < 20) begin
            @(posedge clock); #1; n++;
        end
        checkOutput("latency", n, e.lat);
        for (int i = 0; i < stall; i++) begin
            if (poke) begin
                req_valid = 1'b1; req_op = 2'b01; req_index = idx + 1'b1; req_tag = tag ^ 14'h155;
            end
            @(posedge clock); #1;
            checkOutput("stall_valid", resp_valid, 1);
            checkOutput("stall_req_ready", req_ready, 0);
            checkOutput("stall_hit", resp_hit, e.hit);
            checkOutput("stall_way", resp_way, e.way);
            checkOutput("stall_state", resp_state, e.st);
            checkOutput("stall_vtag", resp_victim_tag, e.vt);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clock); #1;
        resp_ready = 1'b0;
        checkOutput("exit_valid", resp_valid, 0);
        checkOutput("exit_req_ready", req_ready, 1);
    endtask

    // FILL abandoned by reset in its WR cycle: the write pulse is seen, then must vanish.
    task automatic abortFill(input logic [AW-1:0] idx, input logic [TW-1:0] tag, input logic [1:0] ns);
        exp_t e;
        model(2'b01, idx, tag, ns, e);
        wr_q.push_back(e);
        req_op = 2'b01; req_index = idx; req_tag = tag; req_state = ns;
        req_valid = 1'b1; resp_ready = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        checkOutput("abort_we_way", e.wway ? tag_we1 : tag_we0, 1);
        @(negedge clock); #1;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_we0", tag_we0, 0);
        checkOutput("abort_we1", tag_we1, 0);
        checkOutput("abort_resp_valid", resp_valid, 0);
        checkOutput("abort_req_ready", req_ready, 1);
        for (int s = 0; s < DEPTH; s++) m_lru[s] = 1'b0;
        @(posedge clock); #1;
        rst_n = 1'b1;
        resp_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checkOutput("abort_no_resp", resp_valid, 0);
        checkOutput("abort_idle_ready", req_ready, 1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [TW-1:0] pool [6];
        pool[0] = 14'h0A5; pool[1] = 14'h1B0; pool[2] = 14'h2C3;
        pool[3] = 14'h033; pool[4] = 14'h3FF; pool[5] = 14'h111;

        rst_n = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
        req_op = 2'b00; req_index = '0; req_tag = '0; req_state = 2'b00;
        pre_we = 1'b0; pre_way = 1'b0; pre_idx = '0; pre_data = '0;
        for (int s = 0; s < DEPTH; s++) m_lru[s] = 1'b0;
        @(posedge clock); #1;
        for (int w = 0; w < 2; w++)
            for (int s = 0; s < DEPTH; s++)
                preload(w[0], s[AW-1:0], 2'b00, TW'($urandom));

        checkOutput("rst_req_ready", req_ready, 1);
        checkOutput("rst_resp_valid", resp_valid, 0);
        checkOutput("rst_we", {tag_we1, tag_we0}, 0);
        checkOutput("rst_tag_addr", tag_addr, 0);
        checkOutput("rst_resp_hit", resp_hit, 0);
        checkOutput("rst_tag_din", tag_din, 0);
        rst_n = 1'b1;
        @(posedge clock); #1;

        applyStimulus(2'b00, 3'd2, 14'h0A5, 2'b00, 0, 1'b0);
        applyStimulus(2'b01, 3'd2, 14'h0A5, 2'b01, 0, 1'b0);
        applyStimulus(2'b01, 3'd2, 14'h1B0, 2'b01, 0, 1'b0);
        applyStimulus(2'b00, 3'd2, 14'h0A5, 2'b00, 0, 1'b0);
        applyStimulus(2'b01, 3'd2, 14'h2C3, 2'b10, 0, 1'b0);
        applyStimulus(2'b10, 3'd2, 14'h2C3, 2'b00, 0, 1'b0);
        applyStimulus(2'b00, 3'd2, 14'h2C3, 2'b00, 0, 1'b0);
        applyStimulus(2'b10, 3'd2, 14'h3FF, 2'b01, 0, 1'b0);
        preload(1'b0, 3'd5, 2'b01, 14'h033);
        preload(1'b1, 3'd5, 2'b01, 14'h033);
        applyStimulus(2'b00, 3'd5, 14'h033, 2'b00, 0, 1'b0);
        applyStimulus(2'b11, 3'd2, 14'h0A5, 2'b00, 0, 1'b0);
        applyStimulus(2'b00, 3'd2, 14'h0A5, 2'b00, 5, 1'b1);
        abortFill(3'd2, 14'h111, 2'b10);
        applyStimulus(2'b00, 3'd2, 14'h111, 2'b00, 0, 1'b0);

        for (int i = 0; i < 200; i++) begin
            applyStimulus(2'($urandom_range(0, 3)), AW'($urandom_range(0, DEPTH - 1)),
                          pool[$urandom_range(0, 5)], 2'($urandom_range(0, 2)),
                          int'($urandom_range(0, 2)), bit'($urandom_range(0, 1)));
        end

        for (int s = 0; s < DEPTH; s++) begin
            checkOutput("final_mem0", mem0[s], {m_st[0][s], m_tag[0][s]});
            checkOutput("final_mem1", mem1[s], {m_st[1][s], m_tag[1][s]});
        end
        checkOutput("resp_q_empty", resp_q.size(), 0);
        checkOutput("wr_q_empty", wr_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
